// File: rtl/sar_scan_sequencer_if.sv
// Bundle between the scan sequencer, its control layer, the shared SAR ADC
// and the result consumer. The sequencer uses the slave view; whatever
// drives requests, ADC status and result_ready uses the master view.
interface sar_scan_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10,
  parameter int CH_W   = $clog2(NUM_CH)
);
  // Scan control
  logic [NUM_CH-1:0] ch_enable;
  logic              start;
  logic              continuous;
  logic              busy;
  logic              timeout_err;
  logic              err_clear;
  // ADC side
  logic [CH_W-1:0]   mux_sel;
  logic              hold_digital;
  logic              adc_eoc;
  logic [DATA_W-1:0] adc_result;
  // Result stream
  logic [DATA_W-1:0] result_data;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output ch_enable, start, continuous, err_clear,
    output adc_eoc, adc_result, result_ready,
    input  busy, timeout_err, mux_sel, hold_digital,
    input  result_data, result_ch, result_valid
  );

  modport slave (
    input  ch_enable, start, continuous, err_clear,
    input  adc_eoc, adc_result, result_ready,
    output busy, timeout_err, mux_sel, hold_digital,
    output result_data, result_ch, result_valid
  );
endinterface

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan scheduler for a shared SAR ADC. Walks the enabled
// channels in ascending order: selects the mux, lets it settle, requests a
// hold/conversion, waits for a rising end-of-conversion and presents the
// tagged code on a valid/ready stream. A conversion that never completes
// raises a sticky timeout flag and the scan moves on without a result.
module sar_scan_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 10,
  parameter int SETTLE_CYCLES = 2,
  parameter int CONV_TIMEOUT  = 64,
  parameter int CH_W          = $clog2(NUM_CH)
) (
  input logic                 clk,
  input logic                 reset,
  sar_scan_sequencer_if.slave bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD,
    S_CONVERT,
    S_STORE
  } state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_mask;
  logic [CH_W-1:0]     r_ch;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_eoc_d;
  logic [DATA_W-1:0]   r_result_data;
  logic [CH_W-1:0]     r_result_ch;
  logic                r_result_valid;
  logic                r_timeout_err;

  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   w_mask_nxt;
  logic [CH_W-1:0]     w_ch_nxt;
  logic [SET_W-1:0]    w_settle_nxt;
  logic [TO_W-1:0]     w_to_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [CH_W-1:0]     w_rch_nxt;
  logic                w_valid_nxt;
  logic                w_terr_set;
  logic                w_advance;
  logic                w_eoc_rise;

  logic                w_first_vld;
  logic [CH_W-1:0]     w_first_ch;
  logic                w_next_vld;
  logic [CH_W-1:0]     w_next_ch;

  // Channel search: lowest bit of the live enable mask (scan start or
  // rescan) and next bit above the current channel in the latched mask.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_ch  = '0;
    w_next_vld  = 1'b0;
    w_next_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_enable[i]) begin
        w_first_vld = 1'b1;
        w_first_ch  = CH_W'(i);
      end
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next_vld = 1'b1;
        w_next_ch  = CH_W'(i);
      end
    end
  end

  // Only a 0->1 transition on eoc counts as a finished conversion, so a
  // level left high from a previous conversion cannot be captured twice.
  assign w_eoc_rise = bus.adc_eoc & ~r_eoc_d;

  // Next-state and datapath-update logic for the scan FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_ch_nxt     = r_ch;
    w_settle_nxt = r_settle_cnt;
    w_to_nxt     = r_to_cnt;
    w_data_nxt   = r_result_data;
    w_rch_nxt    = r_result_ch;
    w_valid_nxt  = r_result_valid;
    w_terr_set   = 1'b0;
    w_advance    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start && w_first_vld) begin
          w_mask_nxt   = bus.ch_enable;
          w_ch_nxt     = w_first_ch;
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_HOLD;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        w_to_nxt    = '0;
        w_state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        // A real edge on the final allowed cycle still wins over timeout.
        if (w_eoc_rise) begin
          w_data_nxt  = bus.adc_result;
          w_rch_nxt   = r_ch;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_STORE;
        end else if (r_to_cnt == TO_W'(CONV_TIMEOUT - 1)) begin
          w_terr_set = 1'b1;
          w_advance  = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_STORE: begin
        if (bus.result_ready && r_result_valid) begin
          w_valid_nxt = 1'b0;
          w_advance   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Move to the next channel; continuous mode is only consulted once the
    // latched mask is exhausted, and it re-reads the live enable mask.
    if (w_advance) begin
      if (w_next_vld) begin
        w_ch_nxt     = w_next_ch;
        w_settle_nxt = '0;
        w_state_nxt  = S_SETTLE;
      end else if (bus.continuous && w_first_vld) begin
        w_mask_nxt   = bus.ch_enable;
        w_ch_nxt     = w_first_ch;
        w_settle_nxt = '0;
        w_state_nxt  = S_SETTLE;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // State, counters and result registers; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_mask         <= '0;
      r_ch           <= '0;
      r_settle_cnt   <= '0;
      r_to_cnt       <= '0;
      r_result_data  <= '0;
      r_result_ch    <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mask         <= w_mask_nxt;
      r_ch           <= w_ch_nxt;
      r_settle_cnt   <= w_settle_nxt;
      r_to_cnt       <= w_to_nxt;
      r_result_data  <= w_data_nxt;
      r_result_ch    <= w_rch_nxt;
      r_result_valid <= w_valid_nxt;
    end
  end

  // Previous-cycle eoc level for edge detection, tracked in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_eoc_d <= 1'b0;
    end else begin
      r_eoc_d <= bus.adc_eoc;
    end
  end

  // Sticky timeout flag; a clear in the same cycle as a new timeout wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (bus.err_clear) begin
      r_timeout_err <= 1'b0;
    end else if (w_terr_set) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Hold is decoded straight from the state register so the async reset
  // drops it immediately and mux_sel can never move while it is high.
  assign bus.mux_sel      = r_ch;
  assign bus.hold_digital = (r_state == S_HOLD) || (r_state == S_CONVERT);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_data  = r_result_data;
  assign bus.result_ch    = r_result_ch;
  assign bus.result_valid = r_result_valid;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Directed + randomized bench for sar_scan_sequencer. An ADC model answers
// each hold request after a random delay with a per-channel code; expected
// result streams are built from the enable mask (ascending set bits).
module tb_sar_scan_sequencer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 10;
  localparam int CH_W   = 2;
  localparam int CONV_TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sar_scan_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  sar_scan_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SETTLE_CYCLES(2),
    .CONV_TIMEOUT(CONV_TIMEOUT), .CH_W(CH_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] codes [NUM_CH];
  logic adc_auto  = 1'b1;
  logic adc_stuck = 1'b0;
  logic m_eoc = 1'b0;
  logic [DATA_W-1:0] m_res = '0;
  logic man_eoc = 1'b0;
  logic [DATA_W-1:0] man_res = '0;

  assign bus.adc_eoc    = adc_auto ? m_eoc : man_eoc;
  assign bus.adc_result = adc_auto ? m_res : man_res;

  // ADC model: eoc rises a random 2..6 sampled cycles after hold goes high
  // and falls once hold is released.
  initial begin : adc_model
    int hold_cyc;
    int dly;
    hold_cyc = 0;
    dly = 2;
    forever begin
      @(posedge clk); #1;
      if (bus.hold_digital) begin
        if (hold_cyc == 0) dly = adc_stuck ? 100000 : int'($urandom_range(2, 6));
        hold_cyc++;
        if (hold_cyc == dly) begin
          m_eoc = 1'b1;
          m_res = codes[bus.mux_sel];
        end
      end else begin
        hold_cyc = 0;
        m_eoc = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] mask);
    bus.ch_enable = mask;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!bus.result_valid && w < 300) begin
      step();
      w++;
    end
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    repeat ($urandom_range(0, 2)) step();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    check({tag, "_vclr"}, 32'(bus.result_valid), 32'd0);
  endtask

  task automatic expect_result(input string tag, input int ch, input logic [DATA_W-1:0] dat);
    wait_valid(tag);
    check({tag, "_ch"}, 32'(bus.result_ch), 32'(ch));
    check({tag, "_data"}, 32'(bus.result_data), 32'(dat));
    handshake(tag);
  endtask

  task automatic randomize_codes();
    for (int c = 0; c < NUM_CH; c++) codes[c] = DATA_W'($urandom);
  endtask

  // One non-continuous scan: results must be every set bit, ascending.
  task automatic run_scan(input logic [NUM_CH-1:0] mask, input string tag);
    int q_ch[$];
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) q_ch.push_back(c);
    pulse_start(mask);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    foreach (q_ch[k]) expect_result($sformatf("%s_r%0d", tag, k), q_ch[k], codes[q_ch[k]]);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin : stimulus
    int w;
    int hold_cnt;
    logic seen_valid;
    int seq[$];
    logic [NUM_CH-1:0] rmask;

    bus.ch_enable = '0;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.result_ready = 1'b0;
    bus.err_clear = 1'b0;
    for (int c = 0; c < NUM_CH; c++) codes[c] = '0;

    // Reset state
    repeat (3) step();
    check("rst_mux", 32'(bus.mux_sel), 32'd0);
    check("rst_hold", 32'(bus.hold_digital), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_data", 32'(bus.result_data), 32'd0);
    check("rst_rch", 32'(bus.result_ch), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    reset = 1'b1;
    step();

    // Single scan with directed codes and hold timing
    codes[1] = 10'h08A;
    codes[3] = 10'h184;
    pulse_start(4'b1010);
    check("scan_mux", 32'(bus.mux_sel), 32'd1);
    check("scan_busy", 32'(bus.busy), 32'd1);
    step();
    check("scan_hold_early", 32'(bus.hold_digital), 32'd0);
    step();
    check("scan_hold_rise", 32'(bus.hold_digital), 32'd1);
    expect_result("scan_r0", 1, 10'h08A);
    expect_result("scan_r1", 3, 10'h184);
    check("scan_idle", 32'(bus.busy), 32'd0);

    // Backpressure: 20 stalled cycles with everything frozen
    randomize_codes();
    pulse_start(4'b0011);
    wait_valid("bp_first");
    check("bp_first_ch", 32'(bus.result_ch), 32'd0);
    check("bp_first_data", 32'(bus.result_data), 32'(codes[0]));
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("bp_stall%0d", i),
            {17'd0, bus.result_valid, bus.result_data, bus.result_ch, bus.mux_sel, bus.hold_digital},
            {17'd0, 1'b1, codes[0], 2'd0, 2'd0, 1'b0});
    end
    handshake("bp_first");
    expect_result("bp_second", 1, codes[1]);
    check("bp_idle", 32'(bus.busy), 32'd0);

    // Timeout: ADC never answers
    adc_stuck = 1'b1;
    pulse_start(4'b0001);
    w = 0;
    hold_cnt = 0;
    seen_valid = 1'b0;
    while (!bus.timeout_err && w < 300) begin
      step();
      w++;
      if (bus.hold_digital) hold_cnt++;
      if (bus.result_valid) seen_valid = 1'b1;
    end
    check("to_flag", 32'(bus.timeout_err), 32'd1);
    check("to_hold_cycles", 32'(hold_cnt), 32'(CONV_TIMEOUT + 1));
    check("to_no_result", 32'(seen_valid), 32'd0);
    check("to_idle", 32'(bus.busy), 32'd0);
    step();
    check("to_sticky", 32'(bus.timeout_err), 32'd1);
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    check("to_clear", 32'(bus.timeout_err), 32'd0);
    adc_stuck = 1'b0;

    // Continuous: two passes over 0,1,2; continuous dropped during pass two
    randomize_codes();
    bus.continuous = 1'b1;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) seq.push_back(c);
    pulse_start(4'b0111);
    foreach (seq[k]) begin
      expect_result($sformatf("cont_r%0d", k), seq[k], codes[seq[k]]);
      if (k == 3) bus.continuous = 1'b0;
    end
    check("cont_idle", 32'(bus.busy), 32'd0);
    repeat (10) step();
    check("cont_no_more", {30'd0, bus.result_valid, bus.busy}, 32'd0);

    // start with an empty mask is ignored
    pulse_start(4'b0000);
    check("empty_busy", 32'(bus.busy), 32'd0);
    step();
    check("empty_hold", {30'd0, bus.hold_digital, bus.busy}, 32'd0);

    // start while busy and mid-scan enable changes are ignored
    randomize_codes();
    pulse_start(4'b0100);
    pulse_start(4'b0001);
    check("busy_mux", 32'(bus.mux_sel), 32'd2);
    expect_result("busy_r0", 2, codes[2]);
    check("busy_idle", 32'(bus.busy), 32'd0);

    // eoc already high entering CONVERT must not capture
    adc_auto = 1'b0;
    man_eoc = 1'b1;
    man_res = 10'h155;
    pulse_start(4'b0001);
    w = 0;
    while (!bus.hold_digital && w < 20) begin
      step();
      w++;
    end
    repeat (6) step();
    check("stuck_nocap", 32'(bus.result_valid), 32'd0);
    check("stuck_hold", 32'(bus.hold_digital), 32'd1);
    man_eoc = 1'b0;
    step();
    man_eoc = 1'b1;
    man_res = 10'h2AA;
    step();
    check("stuck_valid", 32'(bus.result_valid), 32'd1);
    check("stuck_data", 32'(bus.result_data), 32'h2AA);
    check("stuck_ch", 32'(bus.result_ch), 32'd0);
    handshake("stuck");
    man_eoc = 1'b0;
    adc_auto = 1'b1;
    check("stuck_idle", 32'(bus.busy), 32'd0);

    // Randomized scans against the mask model
    for (int s = 0; s < 5; s++) begin
      randomize_codes();
      rmask = NUM_CH'($urandom_range(1, 15));
      run_scan(rmask, $sformatf("rnd%0d", s));
    end

    // Async reset in the middle of a conversion
    adc_stuck = 1'b1;
    pulse_start(4'b0010);
    w = 0;
    while (!bus.hold_digital && w < 20) begin
      step();
      w++;
    end
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    check("arst_hold", 32'(bus.hold_digital), 32'd0);
    check("arst_valid", 32'(bus.result_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_mux", 32'(bus.mux_sel), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    adc_stuck = 1'b0;
    step();
    randomize_codes();
    run_scan(4'b1001, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_scan_sequencer.md
Name: sar_scan_sequencer

Overview:
- Multi-channel conversion scheduler for the shared ideal SAR ADC (sample-and-hold, comparator, SAR register).
- Steps an analog input mux through the enabled channels and drives the ADC hold control for each one.
- Waits for end-of-conversion, then presents each tagged result on a valid/ready stream.
- Sits between the control/register layer and the ADC instance; the ADC divided clock is generated elsewhere and is not its concern.

Parameters:
- NUM_CH, 4: number of analog channels (2..16).
- DATA_W, 10: ADC result width.
- SETTLE_CYCLES, 2: clk cycles mux_sel is stable before hold asserts (>=1).
- CONV_TIMEOUT, 64: max clk cycles in CONVERT waiting for eoc (>=2).
- CH_W, $clog2(NUM_CH): channel index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ch_enable  in  NUM_CH  channel enable mask, latched at scan start.
- start  in  1  single-cycle scan launch request.
- continuous  in  1  1 = rescan indefinitely.
- mux_sel  out  CH_W  analog mux channel select.
- hold_digital  out  1  S&H hold / conversion request to ADC.
- adc_eoc  in  1  ADC end-of-conversion (level).
- adc_result  in  DATA_W  ADC code, valid while adc_eoc=1.
- result_data  out  DATA_W  captured conversion code.
- result_ch  out  CH_W  channel of result_data.
- result_valid  out  1  result stream valid.
- result_ready  in  1  result stream ready.
- busy  out  1  scan in progress (state != IDLE).
- timeout_err  out  1  sticky conversion-timeout flag.
- err_clear  in  1  clears timeout_err.

Behaviour:
- Reset (async assert, sync release): state=IDLE, mux_sel=0, hold_digital=0, result_data=0, result_ch=0, result_valid=0, busy=0, timeout_err=0, all counters=0, latched mask=0.
- States: IDLE, SETTLE, HOLD, CONVERT, STORE.
- IDLE:
  - start=1 with ch_enable!=0: latch mask, pick lowest set bit as channel, drive mux_sel to it, go to SETTLE.
  - start=1 with ch_enable==0: ignored.
  - start while busy: ignored.
- SETTLE: count SETTLE_CYCLES cycles with hold_digital=0, then go to HOLD.
- HOLD: assert hold_digital=1 for one cycle, clear timeout counter, go to CONVERT.
- CONVERT: hold_digital stays 1; increment timeout counter each cycle.
  - adc_eoc rising edge (eoc=1 and previous-cycle eoc=0): capture adc_result into result_data and the current channel into result_ch; set result_valid the next cycle; drop hold_digital; go to STORE.
  - eoc already high on entry is not a rising edge and does not capture.
  - Counter reaches CONV_TIMEOUT without an edge: set timeout_err, drop hold_digital, emit no result, advance to next channel.
- STORE: hold result_valid, result_data and result_ch stable until result_ready=1 in a cycle with result_valid=1, then clear result_valid and advance. Backpressure stalls the scan; nothing is dropped.
- Advance:
  - Next higher set bit of the latched mask -> SETTLE with the new mux_sel.
  - No higher bit: continuous=1 -> re-latch ch_enable and restart at its lowest set bit (IDLE if it is now 0).
  - No higher bit and continuous=0 -> IDLE.
  - continuous is sampled only at end of scan.
- Timing: start at edge N -> mux_sel valid at N+1; hold_digital rises at N+1+SETTLE_CYCLES; eoc edge seen at cycle E -> result_valid at E+1.
- mux_sel changes only on entry to SETTLE; it never changes while hold_digital=1.
- timeout_err: err_clear has priority over a simultaneous new timeout (clear wins; the new event is lost). err_clear does not affect the scan.
- ch_enable changes mid-scan have no effect until the next latch.
- Reset mid-conversion: hold_digital drops immediately (async); any pending result is discarded.

Test Plan:
- Single scan: ch_enable=4'b1010, continuous=0, start pulse, ADC model returns 10'h08A on ch1 and 10'h184 on ch3 -> results (ch1,0x08A) then (ch3,0x184); busy falls after the second handshake; hold_digital rises 3 cycles after start.
- Backpressure: result_ready=0 for 20 cycles after first result -> result_valid/data/ch stable for all 20 cycles, mux_sel not advanced, no hold_digital pulse; scan resumes after ready=1.
- Timeout: ch_enable=4'b0001, ADC never asserts eoc -> after 64 CONVERT cycles timeout_err=1, no result_valid, return to IDLE; err_clear pulse -> timeout_err=0.
- Continuous: ch_enable=4'b0111, continuous=1 -> result_ch sequence 0,1,2,0,1,2; deassert continuous mid-scan -> finishes through ch2, then IDLE.
- Edge cases: start with ch_enable=0 -> stays IDLE, busy=0; start while busy -> ignored; eoc held high entering CONVERT -> no capture until it falls and rises again.
- Reset mid-CONVERT: reset=0 asynchronously -> hold_digital=0, result_valid=0, busy=0 in the same cycle; after release, a new start performs a clean scan.
